// File: rtl/reaction_ctrl.sv
//------------------------------------------------------------------------------
// Module   : reaction_ctrl
// Brief    : Reaction-time game controller driving a shared up-counting ms timer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reaction_ctrl #(
    parameter int MAX_MS       = 2047,
    parameter int MIN_DELAY_MS = 500,
    parameter int TIMEOUT_MS   = 1000,
    localparam int W           = $clog2(MAX_MS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         react,
    input  logic [W-1:0] delay_ms,
    input  logic [W-1:0] timer_value,
    output logic         timer_reset,
    output logic         timer_up,
    output logic         timer_enable,
    output logic         led_go,
    output logic [W-1:0] result_ms,
    output logic         result_valid,
    output logic         false_start,
    output logic         timeout,
    output logic         busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_GO    = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;
    localparam logic [2:0] ST_TOUT  = 3'd5;

    localparam logic [W-1:0] C_MIN_DELAY = W'(MIN_DELAY_MS);
    localparam logic [W-1:0] C_TIMEOUT   = W'(TIMEOUT_MS);

    logic [2:0]   r_state;
    logic [2:0]   w_state_nx;
    logic [W-1:0] r_delay_lat;
    logic [W-1:0] r_result_ms;
    logic         r_result_valid;
    logic         r_false_start;
    logic         r_timeout;
    logic         w_start_ok;
    logic         w_wait_hit;
    logic         w_go_tout;

    // Unused encodings behave like IDLE so a start can always recover the FSM.
    assign w_start_ok = start && (r_state != ST_WAIT) && (r_state != ST_GO);
    assign w_wait_hit = (r_state == ST_WAIT) && !react && (timer_value >= r_delay_lat);
    assign w_go_tout  = (r_state == ST_GO) && !react && (timer_value >= C_TIMEOUT);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_WAIT: begin
                if (react)           w_state_nx = ST_FAULT;
                else if (w_wait_hit) w_state_nx = ST_GO;
            end
            ST_GO: begin
                if (react)          w_state_nx = ST_DONE;
                else if (w_go_tout) w_state_nx = ST_TOUT;
            end
            ST_IDLE, ST_DONE, ST_FAULT, ST_TOUT: begin
                if (w_start_ok) w_state_nx = ST_WAIT;
            end
            default: w_state_nx = w_start_ok ? ST_WAIT : ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_delay_lat    <= '0;
            r_result_ms    <= '0;
            r_result_valid <= 1'b0;
            r_false_start  <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_result_valid <= 1'b0;
            if (w_start_ok) begin
                r_delay_lat   <= (delay_ms < C_MIN_DELAY) ? C_MIN_DELAY : delay_ms;
                r_false_start <= 1'b0;
                r_timeout     <= 1'b0;
            end
            if (r_state == ST_WAIT && react) begin
                r_false_start <= 1'b1;
            end
            // A react in the same cycle as the timeout still counts as a valid result.
            if (r_state == ST_GO && react) begin
                r_result_ms    <= timer_value;
                r_result_valid <= 1'b1;
            end else if (w_go_tout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timer_reset  = (r_state == ST_IDLE) || w_start_ok || w_wait_hit;
    assign timer_up     = 1'b1;
    assign timer_enable = (r_state == ST_WAIT) || (r_state == ST_GO);
    assign busy         = (r_state == ST_WAIT) || (r_state == ST_GO);
    assign led_go       = (r_state == ST_GO);
    assign result_ms    = r_result_ms;
    assign result_valid = r_result_valid;
    assign false_start  = r_false_start;
    assign timeout      = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_reaction_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_reaction_ctrl
// Brief    : Directed and random trials of reaction_ctrl against a trial-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_reaction_ctrl;

    localparam int W          = 11;
    localparam int MIN_DELAY  = 500;
    localparam int TIMEOUT    = 1000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         react = 1'b0;
    logic [W-1:0] delay_ms = '0;
    logic [W-1:0] timer_value = '0;
    logic         timer_reset, timer_up, timer_enable, led_go;
    logic [W-1:0] result_ms;
    logic         result_valid, false_start, timeout, busy;

    int total = 0;
    int bad   = 0;
    int exp_res = 0;

    reaction_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .react(react),
        .delay_ms(delay_ms), .timer_value(timer_value),
        .timer_reset(timer_reset), .timer_up(timer_up), .timer_enable(timer_enable),
        .led_go(led_go), .result_ms(result_ms), .result_valid(result_valid),
        .false_start(false_start), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // The shared ms timer, advancing once per clock for a compact run.
    always @(posedge clk) begin
        if (timer_reset)       timer_value <= '0;
        else if (timer_enable) timer_value <= timer_value + 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_after_reset(input string tag);
        chk({tag, "_led"}, led_go, 0);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_fs"}, false_start, 0);
        chk({tag, "_to"}, timeout, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_res"}, result_ms, 0);
        chk({tag, "_treset"}, timer_reset, 1);
        chk({tag, "_tup"}, timer_up, 1);
        chk({tag, "_ten"}, timer_enable, 0);
    endtask

    // mode 0: react in WAIT at timer v; 1: react in GO at v; 2: no react; 3: reset in GO at v
    task automatic trial(input int d, input int mode, input int v, input bit inj);
        int  dl;
        int  n;
        bit  reached;
        dl = (d < MIN_DELAY) ? MIN_DELAY : d;
        start    = 1'b1;
        delay_ms = W'(d);
        #1;
        chk("accept_treset", timer_reset, 1);
        tick();
        start = 1'b0;
        chk("wait_busy", busy, 1);
        chk("wait_flags", {false_start, timeout}, 0);
        reached = 1'b0;
        n = 0;
        while (!reached && n < 3000) begin
            n++;
            if (inj && n == 10) begin
                start    = 1'b1;
                delay_ms = W'(2000);
                #1;
                chk("wait_start_ignored", timer_reset, 0);
            end
            if (mode == 0 && int'(timer_value) == v) begin
                react = 1'b1;
                tick();
                react = 1'b0;
                start = 1'b0;
                chk("fault_fs", false_start, 1);
                chk("fault_led", led_go, 0);
                chk("fault_busy", busy, 0);
                chk("fault_ten", timer_enable, 0);
                chk("fault_res", result_ms, exp_res);
                return;
            end else if (int'(timer_value) >= dl) begin
                #1;
                chk("thresh_treset", timer_reset, 1);
                tick();
                start = 1'b0;
                reached = 1'b1;
                chk("go_led_rise", led_go, 1);
            end else begin
                chk("wait_led", led_go, 0);
                tick();
                start = 1'b0;
            end
        end
        chk("wait_reached", reached, 1);
        if (!reached) return;
        reached = 1'b0;
        n = 0;
        while (n < 1100) begin
            if (mode == 3 && int'(timer_value) == v) begin
                reset = 1'b1;
                start = 1'b1;
                react = 1'b1;
                tick();
                reset = 1'b0;
                start = 1'b0;
                react = 1'b0;
                #1;
                exp_res = 0;
                chk_idle_after_reset("go_reset");
                return;
            end
            if (mode == 1 && int'(timer_value) == v) begin
                react = 1'b1;
                tick();
                react = 1'b0;
                exp_res = v;
                chk("done_rv", result_valid, 1);
                chk("done_res", result_ms, v);
                chk("done_to", timeout, 0);
                chk("done_led", led_go, 0);
                chk("done_busy", busy, 0);
                tick();
                chk("done_rv_pulse", result_valid, 0);
                chk("done_res_hold", result_ms, v);
                return;
            end
            if (int'(timer_value) >= TIMEOUT) begin
                tick();
                chk("tout_to", timeout, 1);
                chk("tout_led", led_go, 0);
                chk("tout_ten", timer_enable, 0);
                chk("tout_res", result_ms, exp_res);
                chk("tout_rv", result_valid, 0);
                react = 1'b1;
                tick();
                react = 1'b0;
                chk("tout_react_rv", result_valid, 0);
                chk("tout_react_res", result_ms, exp_res);
                chk("tout_react_to", timeout, 1);
                return;
            end
            chk("go_led", led_go, 1);
            tick();
            n++;
        end
        chk("go_finished", reached, 1);
    endtask

    initial begin
        int d, mode, v, dl;
        reset = 1'b1;
        start = 1'b1;
        react = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        start = 1'b0;
        react = 1'b0;
        #1;
        chk_idle_after_reset("reset");
        react = 1'b1;
        tick();
        react = 1'b0;
        chk("idle_react_ignored", busy, 0);

        trial(800, 1, 237, 1'b0);
        trial(100, 1, 5, 1'b0);
        trial(900, 0, 400, 1'b0);
        trial(600, 2, 0, 1'b0);
        trial(500, 1, 1000, 1'b0);
        trial(700, 0, 700, 1'b0);
        trial(650, 1, 42, 1'b1);
        trial(520, 3, 300, 1'b0);
        trial(0, 1, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            d    = int'($urandom_range(0, 1200));
            mode = int'($urandom_range(0, 2));
            dl   = (d < MIN_DELAY) ? MIN_DELAY : d;
            v    = (mode == 0) ? int'($urandom_range(0, dl)) : int'($urandom_range(0, TIMEOUT));
            trial(d, mode, v, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
